// File: rtl/cpu_types_pkg.sv
// Shared CPU/bus types: data word, memory responder states, and the
// poison value returned for misaligned reads.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      IDLE,
      ACCESS
   } mem_state_t;

   localparam word_t BAD_DATA = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x 32 word array: synchronous write, combinational read,
// whole array cleared on reset.
module mem_word_array
   import cpu_types_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  word_t         wdata,
   input  logic [AW-1:0] raddr,
   output word_t         rdata
);

   word_t mem [DEPTH];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for bus_mem_if: acks each dREN/dWEN access after LAT
// wait states (LAT legal 1..15). Optional MEM_ALIGN_CHECK_EN adds misalign port.
module bus_mem_responder
   import cpu_types_pkg::*;
#(
   parameter int LAT   = 2,
   parameter int DEPTH = 1024
) (
   input  logic  CLK,
   input  logic  nRST,
   input  logic  dREN,
   input  logic  dWEN,
   input  word_t daddr,
   input  word_t dstore,
   output logic  dwait,
   output word_t dload
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic  misalign
`endif
);

   localparam int         AW     = $clog2(DEPTH);
   localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

   mem_state_t state, next_state;
   logic [3:0] cnt, cnt_next;
   word_t      lat_addr;
   logic       lat_wr;
   word_t      dload_r;

   logic       req, match, ack, latch_en, bad, we, rd_ack;
   word_t      rdata;

   assign req   = dREN | dWEN;
   // dWEN wins when both are high, so the op bit is simply dWEN.
   assign match = req && (daddr == lat_addr) && (dWEN == lat_wr);

   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      dwait      = 1'b1;
      ack        = 1'b0;
      latch_en   = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               latch_en   = 1'b1;
               cnt_next   = LAT_M1;
               next_state = ACCESS;
            end
         end
         ACCESS: begin
            if (!match) begin
               // Abort: the new request is picked up fresh from IDLE.
               cnt_next   = '0;
               next_state = IDLE;
            end else if (cnt != 4'd0) begin
               cnt_next = cnt - 4'd1;
            end else begin
               ack        = 1'b1;
               dwait      = 1'b0;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= IDLE;
         cnt      <= '0;
         lat_addr <= '0;
         lat_wr   <= 1'b0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
         if (latch_en) begin
            lat_addr <= daddr;
            lat_wr   <= dWEN;
         end
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   assign bad      = (lat_addr[1:0] != 2'b00);
   assign misalign = ack & bad;
`else
   assign bad = 1'b0;
`endif

   // Write data is taken from dstore in the ack cycle, not from the request cycle.
   assign we     = ack & lat_wr & ~bad;
   assign rd_ack = ack & ~lat_wr;

   mem_word_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .CLK   (CLK),
      .nRST  (nRST),
      .we    (we),
      .waddr (lat_addr[AW+1:2]),
      .wdata (dstore),
      .raddr (lat_addr[AW+1:2]),
      .rdata (rdata)
   );

   assign dload = rd_ack ? (bad ? BAD_DATA : rdata) : dload_r;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)       dload_r <= '0;
      else if (rd_ack) dload_r <= dload;
   end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: vector table of single accesses plus
// hand sequences for back-to-back, abort, reset mid-access and misalignment.
module tb_bus_mem_responder;
   import cpu_types_pkg::*;

   localparam int LAT   = 2;
   localparam int DEPTH = 1024;

   logic  CLK = 1'b0;
   logic  nRST;
   logic  dREN, dWEN;
   word_t daddr, dstore;
   logic  dwait;
   word_t dload;
`ifdef MEM_ALIGN_CHECK_EN
   logic  misalign;
`endif

   int    n_pass = 0;
   int    n_total = 0;
   logic  mis_seen;

   always #5 CLK = ~CLK;

   bus_mem_responder #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .CLK    (CLK),
      .nRST   (nRST),
      .dREN   (dREN),
      .dWEN   (dWEN),
      .daddr  (daddr),
      .dstore (dstore),
      .dwait  (dwait),
      .dload  (dload)
`ifdef MEM_ALIGN_CHECK_EN
      ,
      .misalign (misalign)
`endif
   );

   typedef struct {
      logic  wr;
      logic  rd;
      word_t addr;
      word_t data;
      word_t exp_rdata;
   } vec_t;

   task automatic chk(input string name, input word_t act, input word_t exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      else
         n_pass++;
   endtask

   // Caller sits just after a rising edge. Returns the ack index (cycles after
   // the request cycle) and dload sampled in the ack cycle; lat = -1 on timeout.
   task automatic access(input logic wr, input logic rd, input word_t a, input word_t d,
                         output int lat, output word_t rdata);
      dWEN = wr; dREN = rd; daddr = a; dstore = d;
      lat = -1; rdata = '0; mis_seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (!dwait) begin
            lat = k; rdata = dload;
`ifdef MEM_ALIGN_CHECK_EN
            mis_seen = misalign;
`endif
            break;
         end
         @(posedge CLK); #1;
      end
      @(posedge CLK); #1;
      dWEN = 1'b0; dREN = 1'b0;
   endtask

   vec_t  vecs [8];
   int    lat;
   word_t rd;
   int    ack_at [2];
   int    nack;
   int    first_low;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF};
      vecs[2] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0,         32'h0};
      vecs[3] = '{1'b1, 1'b0, 32'h0000_1040, 32'hCAFE_0001, 32'h0};
      vecs[4] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0,         32'hCAFE_0001};
      vecs[5] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0005, 32'h0};
      vecs[6] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_0005};
      vecs[7] = '{1'b1, 1'b0, 32'h0000_0010, 32'hAAAA_5555, 32'h0};

      nRST = 1'b0; dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
      repeat (2) @(negedge CLK);
      chk("reset_dwait", {31'b0, dwait}, 32'h1);
      chk("reset_dload", dload, 32'h0);
      nRST = 1'b1;
      @(posedge CLK); #1;

      for (int i = 0; i < 8; i++) begin
         access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, lat, rd);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
         if (!vecs[i].wr) begin
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            @(negedge CLK);
            chk($sformatf("vec%0d_dload_hold", i), dload, vecs[i].exp_rdata);
            @(posedge CLK); #1;
         end
      end

      // dWEN held across two writes to 0x80; second ack must be LAT+1 later.
      dWEN = 1'b1; daddr = 32'h80; dstore = 32'h11; nack = 0;
      ack_at[0] = -1; ack_at[1] = -1;
      for (int k = 0; k < 20 && nack < 2; k++) begin
         @(negedge CLK);
         if (!dwait) begin ack_at[nack] = k; nack++; end
         @(posedge CLK); #1;
         if (nack == 1) dstore = 32'h22;
      end
      dWEN = 1'b0;
      chk("b2b_ack_count", 32'(nack), 32'd2);
      chk("b2b_first_ack", 32'(ack_at[0]), 32'(LAT));
      chk("b2b_second_ack", 32'(ack_at[1]), 32'(2*LAT + 1));
      access(1'b0, 1'b1, 32'h80, 32'h0, lat, rd);
      chk("b2b_readback", rd, 32'h22);

      // Read 0x10 redirected to 0x14 mid-access: only the 0x14 access acks.
      dREN = 1'b1; daddr = 32'h10; first_low = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (!dwait) begin first_low = k; break; end
         @(posedge CLK); #1;
         daddr = 32'h14;
      end
      chk("abort_redirect_ack", 32'(first_low), 32'(LAT + 2));
      chk("abort_redirect_data", dload, 32'h0);
      @(posedge CLK); #1;
      dREN = 1'b0;

      // Write to 0x10 dropped mid-access: no ack, array unchanged.
      dWEN = 1'b1; daddr = 32'h10; dstore = 32'h1234; first_low = -1;
      @(posedge CLK); #1;
      dWEN = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         if (!dwait && first_low < 0) first_low = k;
         @(posedge CLK); #1;
      end
      chk("abort_drop_no_ack", 32'(first_low), 32'hFFFF_FFFF);
      access(1'b0, 1'b1, 32'h10, 32'h0, lat, rd);
      chk("abort_prior_write_kept", rd, 32'hAAAA_5555);

      // Reset during a write access to 0x30.
      dWEN = 1'b1; daddr = 32'h30; dstore = 32'h7;
      @(posedge CLK); #1;
      nRST = 1'b0;
      #1;
      chk("rst_mid_dwait", {31'b0, dwait}, 32'h1);
      chk("rst_mid_dload", dload, 32'h0);
      dWEN = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK); #1;
      access(1'b0, 1'b1, 32'h30, 32'h0, lat, rd);
      chk("rst_mid_latency", 32'(lat), 32'(LAT));
      chk("rst_mid_readback", rd, 32'h0);
      access(1'b0, 1'b1, 32'h40, 32'h0, lat, rd);
      chk("rst_cleared_array", rd, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
      access(1'b0, 1'b1, 32'h31, 32'h0, lat, rd);
      chk("mis_rd_latency", 32'(lat), 32'(LAT));
      chk("mis_rd_flag", {31'b0, mis_seen}, 32'h1);
      chk("mis_rd_data", rd, BAD_DATA);
      @(negedge CLK);
      chk("mis_rd_dload_reg", dload, BAD_DATA);
      @(posedge CLK); #1;
      access(1'b1, 1'b0, 32'h35, 32'h99, lat, rd);
      chk("mis_wr_flag", {31'b0, mis_seen}, 32'h1);
      access(1'b0, 1'b1, 32'h34, 32'h0, lat, rd);
      chk("mis_wr_suppressed", rd, 32'h0);
      chk("aligned_no_flag", {31'b0, mis_seen}, 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
